// File: rtl/vga_timing_pkg.sv
// Shared raster timing defaults and the line/frame phase encoding.
// Latency: n/a (constants and a pure decode function).
// Backpressure: n/a.
package vga_timing_pkg;

    localparam int CNT_W          = 10;
    localparam int CNT_MAX_TOTAL  = 1 << CNT_W;

    localparam int DEF_H_ACTIVE   = 640;
    localparam int DEF_H_FP       = 16;
    localparam int DEF_H_SYNC     = 96;
    localparam int DEF_H_BP       = 48;
    localparam int DEF_V_ACTIVE   = 480;
    localparam int DEF_V_FP       = 10;
    localparam int DEF_V_SYNC     = 2;
    localparam int DEF_V_BP       = 33;
    localparam int DEF_CLK_DIV    = 4;
    localparam logic DEF_SYNC_POL = 1'b0;

    typedef logic [CNT_W-1:0] cnt_t;
    // One bit wider than a coordinate so a phase boundary of 1024 is representable.
    typedef logic [CNT_W:0]   bound_t;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FP     = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BP     = 2'd3
    } phase_t;

    // Boundaries are cumulative: end of active, end of front porch, end of sync.
    function automatic phase_t decode_phase(
        input cnt_t   pos,
        input bound_t act_end,
        input bound_t fp_end,
        input bound_t sync_end
    );
        bound_t p;
        phase_t ph;
        p = {1'b0, pos};
        if (p < act_end) begin
            ph = PH_ACTIVE;
        end else if (p < fp_end) begin
            ph = PH_FP;
        end else if (p < sync_end) begin
            ph = PH_SYNC;
        end else begin
            ph = PH_BP;
        end
        return ph;
    endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Clock divider producing one pix_tick per CLK_DIV clk cycles.
// Latency: pix_tick decoded combinationally from the divider register.
// Backpressure: none; free-running.
module pixel_tick_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic pix_tick
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div;

    if (CLK_DIV < 1) begin : g_div_err
        $error("pixel_tick_div: CLK_DIV must be >= 1");
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
        end else if (div == DIV_LAST) begin
            div <= '0;
        end else begin
            div <= div + DW'(1);
        end
    end

    // With CLK_DIV=1 div never leaves 0, so the tick is permanently high.
    assign pix_tick = (div == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: h/v counters, phase decode, sync/valid/strobe outputs.
// Latency: every output lags the internal counters by exactly 1 clk.
// Backpressure: none; free-running, consumers qualify with valid.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter int   CLK_DIV  = DEF_CLK_DIV,
    parameter logic SYNC_POL = DEF_SYNC_POL
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             valid,
    output logic             hsync,
    output logic             vsync,
    output logic             pix_tick,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam cnt_t   H_LAST     = cnt_t'(H_TOTAL - 1);
    localparam cnt_t   V_LAST     = cnt_t'(V_TOTAL - 1);
    localparam bound_t H_ACT_END  = bound_t'(H_ACTIVE);
    localparam bound_t H_FP_END   = bound_t'(H_ACTIVE + H_FP);
    localparam bound_t H_SYNC_END = bound_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam bound_t V_ACT_END  = bound_t'(V_ACTIVE);
    localparam bound_t V_FP_END   = bound_t'(V_ACTIVE + V_FP);
    localparam bound_t V_SYNC_END = bound_t'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic SYNC_ON  = SYNC_POL;
    localparam logic SYNC_OFF = ~SYNC_POL;

    if (H_TOTAL > CNT_MAX_TOTAL) begin : g_h_total_err
        $error("vga_timing_gen: H_TOTAL exceeds the 10-bit counter range");
    end
    if (V_TOTAL > CNT_MAX_TOTAL) begin : g_v_total_err
        $error("vga_timing_gen: V_TOTAL exceeds the 10-bit counter range");
    end
    if (H_ACTIVE < 1 || V_ACTIVE < 1 || H_SYNC < 1 || V_SYNC < 1) begin : g_phase_err
        $error("vga_timing_gen: active and sync widths must be non-zero");
    end
    if (CLK_DIV < 1) begin : g_div_err
        $error("vga_timing_gen: CLK_DIV must be >= 1");
    end

    logic   tick;
    logic   new_px;
    cnt_t   h;
    cnt_t   v;
    phase_t h_ph;
    phase_t v_ph;

    pixel_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .pix_tick (tick)
    );

    always_comb begin
        h_ph = decode_phase(h, H_ACT_END, H_FP_END, H_SYNC_END);
        v_ph = decode_phase(v, V_ACT_END, V_FP_END, V_SYNC_END);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h           <= '0;
            v           <= '0;
            // The first cycle after release opens pixel (0,0), so it counts as a fresh pixel.
            new_px      <= 1'b1;
            h_cnt       <= '0;
            v_cnt       <= '0;
            valid       <= 1'b0;
            hsync       <= SYNC_OFF;
            vsync       <= SYNC_OFF;
            pix_tick    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            if (tick) begin
                if (h == H_LAST) begin
                    h <= '0;
                    v <= (v == V_LAST) ? '0 : v + cnt_t'(1);
                end else begin
                    h <= h + cnt_t'(1);
                end
            end
            // Marks the first clk of each pixel period so strobes are not stretched.
            new_px      <= tick;
            h_cnt       <= h;
            v_cnt       <= v;
            valid       <= (h_ph == PH_ACTIVE) && (v_ph == PH_ACTIVE);
            hsync       <= (h_ph == PH_SYNC) ? SYNC_ON : SYNC_OFF;
            vsync       <= (v_ph == PH_SYNC) ? SYNC_ON : SYNC_OFF;
            pix_tick    <= tick;
            line_start  <= new_px && (h == '0);
            frame_start <= new_px && (h == '0) && (v == '0);
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: two instances (default 640x480/div4, and div1 active-high with a short frame)
// compared every clk against an arithmetic raster model indexed by clk count since reset release.
module tb_vga_timing_gen;

    localparam int MAX_BAD = 40;
    localparam int B_VA = 6, B_VFP = 2, B_VS = 2, B_VBP = 3;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       valid;
        logic       hs;
        logic       vs;
        logic       tick;
        logic       ls;
        logic       fs;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a_n, rst_b_n;
    logic [9:0] h_a, v_a, h_b, v_b;
    logic       valid_a, hs_a, vs_a, tick_a, ls_a, fs_a;
    logic       valid_b, hs_b, vs_b, tick_b, ls_b, fs_b;
    obs_t       obs_a, obs_b, exp_a, exp_b;

    int total = 0;
    int bad   = 0;
    int e_a   = 0;
    int e_b   = 0;

    vga_timing_gen dut_a (
        .clk(clk), .rst_n(rst_a_n), .h_cnt(h_a), .v_cnt(v_a), .valid(valid_a),
        .hsync(hs_a), .vsync(vs_a), .pix_tick(tick_a), .line_start(ls_a), .frame_start(fs_a)
    );

    vga_timing_gen #(
        .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP),
        .CLK_DIV(1), .SYNC_POL(1'b1)
    ) dut_b (
        .clk(clk), .rst_n(rst_b_n), .h_cnt(h_b), .v_cnt(v_b), .valid(valid_b),
        .hsync(hs_b), .vsync(vs_b), .pix_tick(tick_b), .line_start(ls_b), .frame_start(fs_b)
    );

    assign obs_a = {h_a, v_a, valid_a, hs_a, vs_a, tick_a, ls_a, fs_a};
    assign obs_b = {h_b, v_b, valid_b, hs_b, vs_b, tick_b, ls_b, fs_b};

    // e = number of rising edges seen with reset released (0 while in reset).
    // Pixel index is floor((e-1)/D); position follows by division over the totals.
    function automatic obs_t model(input int e, input int d,
                                   input int ha, input int hfp, input int hsw, input int hbp,
                                   input int va, input int vfp, input int vsw, input int vbp,
                                   input logic pol);
        obs_t o;
        int q, p, ht, vt, h, v;
        ht = ha + hfp + hsw + hbp;
        vt = va + vfp + vsw + vbp;
        if (e <= 0) begin
            o = '0;
            o.hs = ~pol;
            o.vs = ~pol;
            return o;
        end
        q = e - 1;
        p = q / d;
        h = p % ht;
        v = (p / ht) % vt;
        o.h     = 10'(h);
        o.v     = 10'(v);
        o.valid = (h < ha) && (v < va);
        o.hs    = (h >= ha + hfp && h < ha + hfp + hsw) ? pol : ~pol;
        o.vs    = (v >= va + vfp && v < va + vfp + vsw) ? pol : ~pol;
        o.tick  = (q % d) == d - 1;
        o.ls    = (q % d == 0) && (h == 0);
        o.fs    = o.ls && (v == 0);
        return o;
    endfunction

    function automatic obs_t model_a(input int e);
        return model(e, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
    endfunction

    function automatic obs_t model_b(input int e);
        return model(e, 1, 640, 16, 96, 48, B_VA, B_VFP, B_VS, B_VBP, 1'b1);
    endfunction

    task automatic advance();
        @(posedge clk);
        if (rst_a_n) e_a++; else e_a = 0;
        if (rst_b_n) e_b++; else e_b = 0;
        #1;
        exp_a = model_a(e_a);
        exp_b = model_b(e_b);
    endtask

    task automatic apply_reset(input int cycles);
        @(negedge clk);
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        e_a = 0;
        e_b = 0;
        repeat (cycles) @(negedge clk);
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (obs_a !== model_a(0)) begin
            bad++;
            $display("FAIL reset_a got=%h want=%h", obs_a, model_a(0));
        end
        total++;
        if (obs_b !== model_b(0)) begin
            bad++;
            $display("FAIL reset_b got=%h want=%h", obs_b, model_b(0));
        end
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        advance();
        total++;
        if (!(fs_a === 1'b1 && h_a === 10'd0 && v_a === 10'd0)) begin
            bad++;
            $display("FAIL first_frame_a fs=%b h=%0d v=%0d want fs=1 h=0 v=0", fs_a, h_a, v_a);
        end
        total++;
        if (obs_b !== exp_b) begin
            bad++;
            $display("FAIL first_cycle_b got=%h want=%h", obs_b, exp_b);
        end
    endtask

    task automatic test_pixel_tick();
        int ticks_a, ticks_b;
        ticks_a = 0;
        ticks_b = 0;
        for (int i = 0; i < 64 && bad < MAX_BAD; i++) begin
            advance();
            ticks_a += int'(tick_a);
            ticks_b += int'(tick_b);
            total++;
            if (obs_a !== exp_a) begin
                bad++;
                $display("FAIL tick_cycle_a e=%0d got=%h want=%h", e_a, obs_a, exp_a);
            end
            total++;
            if (obs_b !== exp_b) begin
                bad++;
                $display("FAIL tick_cycle_b e=%0d got=%h want=%h", e_b, obs_b, exp_b);
            end
        end
        total++;
        if (ticks_a != 16) begin
            bad++;
            $display("FAIL tick_count_a got=%0d want=16", ticks_a);
        end
        total++;
        if (ticks_b != 64) begin
            bad++;
            $display("FAIL tick_count_b got=%0d want=64", ticks_b);
        end
    endtask

    task automatic test_line();
        int last_ls_a, per_a, n_ls_a, last_ls_b, per_b;
        int hs_cnt, hs_first, hs_last, h_max;
        logic [9:0] prev_h;
        last_ls_a = -1; per_a = -1; n_ls_a = 0; last_ls_b = -1; per_b = -1;
        hs_cnt = 0; hs_first = -1; hs_last = -1; h_max = 0; prev_h = '0;
        apply_reset($urandom_range(1, 5));
        for (int i = 0; i < 6500 && bad < MAX_BAD; i++) begin
            advance();
            total++;
            if (obs_a !== exp_a) begin
                bad++;
                $display("FAIL line_cycle_a e=%0d got=%h want=%h", e_a, obs_a, exp_a);
            end
            total++;
            if (obs_b !== exp_b) begin
                bad++;
                $display("FAIL line_cycle_b e=%0d got=%h want=%h", e_b, obs_b, exp_b);
            end
            if (ls_a) begin
                if (last_ls_a >= 0 && per_a < 0) per_a = e_a - last_ls_a;
                last_ls_a = e_a;
                n_ls_a++;
            end
            if (ls_b) begin
                if (last_ls_b >= 0 && per_b < 0) per_b = e_b - last_ls_b;
                last_ls_b = e_b;
            end
            if (n_ls_a == 1 && hs_a === 1'b0) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(h_a);
                hs_last = int'(h_a);
            end
            if (int'(h_a) > h_max) h_max = int'(h_a);
            if (prev_h == 10'd799 && h_a !== 10'd799) begin
                total++;
                if (h_a !== 10'd0) begin
                    bad++;
                    $display("FAIL line_wrap_a got=%0d want=0", h_a);
                end
            end
            prev_h = h_a;
        end
        total++;
        if (per_a != 3200) begin bad++; $display("FAIL line_period_a got=%0d want=3200", per_a); end
        total++;
        if (hs_cnt != 384) begin bad++; $display("FAIL hsync_clks_a got=%0d want=384", hs_cnt); end
        total++;
        if (hs_first != 656 || hs_last != 751) begin
            bad++;
            $display("FAIL hsync_span_a got=%0d..%0d want=656..751", hs_first, hs_last);
        end
        total++;
        if (h_max != 799) begin bad++; $display("FAIL h_max_a got=%0d want=799", h_max); end
        total++;
        if (per_b != 800) begin bad++; $display("FAIL line_period_b got=%0d want=800", per_b); end
    endtask

    task automatic test_frame();
        int n_fs, fs_first, per, valid_cnt, vs_cnt, vs_vmin, vs_vmax, sync_in_valid;
        n_fs = 0; fs_first = -1; per = -1; valid_cnt = 0; vs_cnt = 0;
        vs_vmin = 1023; vs_vmax = -1; sync_in_valid = 0;
        apply_reset($urandom_range(1, 5));
        for (int i = 0; i < 11000 && n_fs < 2 && bad < MAX_BAD; i++) begin
            advance();
            total++;
            if (obs_b !== exp_b) begin
                bad++;
                $display("FAIL frame_cycle_b e=%0d got=%h want=%h", e_b, obs_b, exp_b);
            end
            total++;
            if (obs_a !== exp_a) begin
                bad++;
                $display("FAIL frame_cycle_a e=%0d got=%h want=%h", e_a, obs_a, exp_a);
            end
            if (valid_a && (hs_a !== 1'b1 || vs_a !== 1'b1)) sync_in_valid++;
            if (valid_b && (hs_b !== 1'b0 || vs_b !== 1'b0)) sync_in_valid++;
            if (fs_b) begin
                n_fs++;
                if (n_fs == 1) fs_first = e_b;
                else per = e_b - fs_first;
            end
            if (n_fs == 1) begin
                valid_cnt += int'(valid_b);
                if (vs_b === 1'b1) begin
                    vs_cnt++;
                    if (int'(v_b) < vs_vmin) vs_vmin = int'(v_b);
                    if (int'(v_b) > vs_vmax) vs_vmax = int'(v_b);
                end
            end
        end
        total++;
        if (per != 10400) begin bad++; $display("FAIL frame_period_b got=%0d want=10400", per); end
        total++;
        if (valid_cnt != 640 * B_VA) begin
            bad++;
            $display("FAIL valid_ticks_b got=%0d want=%0d", valid_cnt, 640 * B_VA);
        end
        total++;
        if (vs_cnt != 1600) begin bad++; $display("FAIL vsync_clks_b got=%0d want=1600", vs_cnt); end
        total++;
        if (vs_vmin != 8 || vs_vmax != 9) begin
            bad++;
            $display("FAIL vsync_lines_b got=%0d..%0d want=8..9", vs_vmin, vs_vmax);
        end
        total++;
        if (sync_in_valid != 0) begin
            bad++;
            $display("FAIL sync_in_valid got=%0d want=0", sync_in_valid);
        end
    endtask

    task automatic test_mid_reset();
        int tgt_v, tgt_e;
        // Instance A: stop at h=400 on a random early line, any clk within that pixel.
        apply_reset($urandom_range(1, 3));
        tgt_v = $urandom_range(0, 1);
        tgt_e = (tgt_v * 800 + 400) * 4 + $urandom_range(0, 3) + 1;
        for (int i = 0; i < 6000 && e_a < tgt_e && bad < MAX_BAD; i++) begin
            advance();
            total++;
            if (obs_a !== exp_a) begin
                bad++;
                $display("FAIL mid_run_a e=%0d got=%h want=%h", e_a, obs_a, exp_a);
            end
        end
        total++;
        if (h_a !== 10'd400 || v_a !== 10'(tgt_v)) begin
            bad++;
            $display("FAIL mid_pos_a got=%0d,%0d want=400,%0d", h_a, v_a, tgt_v);
        end
        #2;
        rst_a_n = 1'b0;
        e_a = 0;
        #1;
        total++;
        if (obs_a !== model_a(0)) begin
            bad++;
            $display("FAIL mid_async_a got=%h want=%h", obs_a, model_a(0));
        end
        @(negedge clk);
        rst_a_n = 1'b1;
        for (int i = 0; i < 24 && bad < MAX_BAD; i++) begin
            advance();
            total++;
            if (obs_a !== exp_a) begin
                bad++;
                $display("FAIL mid_restart_a e=%0d got=%h want=%h", e_a, obs_a, exp_a);
            end
            if (i == 0) begin
                total++;
                if (fs_a !== 1'b1 || h_a !== 10'd0 || v_a !== 10'd0) begin
                    bad++;
                    $display("FAIL mid_frame_start_a got fs=%b h=%0d v=%0d want fs=1 h=0 v=0", fs_a, h_a, v_a);
                end
            end
        end
        // Instance B: h=400 on a random line of its short frame.
        tgt_v = $urandom_range(0, 12);
        tgt_e = tgt_v * 800 + 400 + 1;
        apply_reset($urandom_range(1, 3));
        for (int i = 0; i < 11000 && e_b < tgt_e && bad < MAX_BAD; i++) begin
            advance();
            total++;
            if (obs_b !== exp_b) begin
                bad++;
                $display("FAIL mid_run_b e=%0d got=%h want=%h", e_b, obs_b, exp_b);
            end
        end
        total++;
        if (h_b !== 10'd400 || v_b !== 10'(tgt_v)) begin
            bad++;
            $display("FAIL mid_pos_b got=%0d,%0d want=400,%0d", h_b, v_b, tgt_v);
        end
        #3;
        rst_b_n = 1'b0;
        e_b = 0;
        #1;
        total++;
        if (obs_b !== model_b(0)) begin
            bad++;
            $display("FAIL mid_async_b got=%h want=%h", obs_b, model_b(0));
        end
        @(negedge clk);
        rst_b_n = 1'b1;
        advance();
        total++;
        if (fs_b !== 1'b1 || h_b !== 10'd0 || v_b !== 10'd0 || tick_b !== 1'b1) begin
            bad++;
            $display("FAIL mid_frame_start_b got fs=%b tick=%b h=%0d v=%0d want fs=1 tick=1 h=0 v=0",
                     fs_b, tick_b, h_b, v_b);
        end
    endtask

    task automatic test_random_runs();
        int len, hold;
        for (int r = 0; r < 3 && bad < MAX_BAD; r++) begin
            apply_reset($urandom_range(1, 4));
            len = $urandom_range(500, 3000);
            for (int i = 0; i < len && bad < MAX_BAD; i++) begin
                advance();
                total++;
                if (obs_a !== exp_a) begin
                    bad++;
                    $display("FAIL rand_a run=%0d e=%0d got=%h want=%h", r, e_a, obs_a, exp_a);
                end
                total++;
                if (obs_b !== exp_b) begin
                    bad++;
                    $display("FAIL rand_b run=%0d e=%0d got=%h want=%h", r, e_b, obs_b, exp_b);
                end
            end
            #($urandom_range(1, 3));
            rst_a_n = 1'b0;
            rst_b_n = 1'b0;
            e_a = 0;
            e_b = 0;
            #1;
            total++;
            if (obs_a !== model_a(0) || obs_b !== model_b(0)) begin
                bad++;
                $display("FAIL rand_async run=%0d got=%h,%h want=%h,%h", r, obs_a, obs_b,
                         model_a(0), model_b(0));
            end
            hold = $urandom_range(1, 4);
            repeat (hold) @(negedge clk);
            rst_a_n = 1'b1;
            rst_b_n = 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_pixel_tick();
        test_line();
        test_frame();
        test_mid_reset();
        test_random_runs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
